// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory stage for the single-cycle RISC-V core.
// It combines a word RAM with asynchronous reads and an MMIO window at
// Addr[31:28]==4'hF. The window holds a console TX FIFO, a STATUS
// register and a CYCLE counter.
// Build option: define DMEM_CYCLE_CNT_EN to build the CYCLE counter.
// When the macro is undefined, offset 0x8 reads 0 and writes to it are ignored.
module dmem_mmio #(
  parameter int MEM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
`ifdef DMEM_CYCLE_CNT_EN
  localparam logic [1:0] OFF_CYCLE  = 2'd2;
`endif

  // ---------------------------------------------------------------------
  // Address decode. The byte lane bits are ignored. The RAM aliases across
  // all upper address bits. The MMIO window uses only Addr[3:2].
  // ---------------------------------------------------------------------
  logic          mmio_sel;
  logic [1:0]    mmio_off;
  logic [AW-1:0] ram_idx;

  assign mmio_sel = (Addr[31:28] == 4'hF);
  assign mmio_off = Addr[3:2];
  assign ram_idx  = Addr[AW+1:2];

  // These address bits are deliberately ignored by the decode.
  // WriteData is only partly consumed when the counter is not built.
  logic unused_bits;
  assign unused_bits = ^{Addr[27:AW+2], Addr[1:0], WriteData};

  // ---------------------------------------------------------------------
  // Word RAM: synchronous write, asynchronous read, not touched by reset.
  // ---------------------------------------------------------------------
  logic [31:0] ram_q [MEM_WORDS];
  logic        ram_we;

  assign ram_we = MemWrite && !mmio_sel;

  // RAM write port
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= WriteData;
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO: a circular buffer with an explicit count.
  // The count lets full and empty be told apart while the pointers are equal.
  // ---------------------------------------------------------------------
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic fifo_full;
  logic fifo_empty;
  logic push_req;
  logic push_ok;
  logic pop;
  logic ovf_clr;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push_req   = MemWrite && mmio_sel && (mmio_off == OFF_TXDATA);
  assign pop        = tx_valid && tx_ready;
  // When the FIFO is full, a pop on the same edge frees the slot that the push needs.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign ovf_clr    = MemWrite && mmio_sel && (mmio_off == OFF_STATUS) && WriteData[2];

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A set and a clear cannot occur together, because each is a separate store.
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage write. A push during reset is dropped.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      fifo_q[wr_ptr_q] <= WriteData[7:0];
    end
  end

  // ---------------------------------------------------------------------
  // CYCLE counter (optional)
  // ---------------------------------------------------------------------
  logic [31:0] cycle_rd;

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] cycle_q, cycle_d;

  // The counter increments every clock. A store takes priority and loads the value exactly.
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (MemWrite && mmio_sel && (mmio_off == OFF_CYCLE)) begin
      cycle_d = WriteData;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = 32'h0;
`endif

  // ---------------------------------------------------------------------
  // Load path. It depends only on the address and the registered state,
  // and never on the same-cycle WriteData.
  // ---------------------------------------------------------------------
  logic [31:0] status_word;

  assign status_word = {16'h0000, 8'(count_q), 5'b00000, ovf_q, fifo_empty, fifo_full};

  // Read multiplexer
  always_comb begin
    ReadData = 32'h0;
    if (mmio_sel) begin
      case (mmio_off)
        OFF_STATUS: ReadData = status_word;
        2'd2:       ReadData = cycle_rd;
        default:    ReadData = 32'h0;
      endcase
    end else begin
      ReadData = ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed self-checking bench for dmem_mmio.
// It uses MEM_WORDS=64 and FIFO_DEPTH=8. The CYCLE expectations follow DMEM_CYCLE_CNT_EN.
module tb_dmem_mmio;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks;
  int failures;

  localparam logic [31:0] A_TX     = 32'hF000_0000;
  localparam logic [31:0] A_STATUS = 32'hF000_0004;
  localparam logic [31:0] A_CYCLE  = 32'hF000_0008;
  localparam logic [31:0] A_RSVD   = 32'hF000_000C;

  dmem_mmio #(.MEM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance one clock and return 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
    WriteData = 32'h0;
  endtask

  // Combinational load; it does not consume a clock.
  task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    check_val(tag, ReadData, exp);
  endtask

  function automatic logic [31:0] cyc_exp(input logic [31:0] v);
`ifdef DMEM_CYCLE_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    Addr      = 32'h0;
    WriteData = 32'h0;
    tx_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and test 5: CYCLE counting
    load_check("rst_cycle0", A_CYCLE, 32'h0);
    load_check("rst_status", A_STATUS, 32'h0000_0002);
    #1;
    check_val("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_val("rst_tx_data", 32'(tx_data), 32'h0);
    tick();
    load_check("cycle1", A_CYCLE, cyc_exp(32'h1));
    tick();
    load_check("cycle2", A_CYCLE, cyc_exp(32'h2));
    store(A_CYCLE, 32'hFFFF_FFFE);
    load_check("cycle_load", A_CYCLE, cyc_exp(32'hFFFF_FFFE));
    tick();
    load_check("cycle_max", A_CYCLE, cyc_exp(32'hFFFF_FFFF));
    tick();
    load_check("cycle_wrap", A_CYCLE, 32'h0);

    // Test 1: RAM store, load and aliasing
    store(32'h0000_0010, 32'hDEAD_BEEF);
    load_check("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
    load_check("ram_bytelane", 32'h0000_0013, 32'hDEAD_BEEF);
    load_check("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    store(32'h0000_0020, 32'hCAFE_F00D);
    load_check("ram_neighbour", 32'h0000_0010, 32'hDEAD_BEEF);
    store(A_RSVD, 32'h1234_5678);
    load_check("rsvd_read", A_RSVD, 32'h0);
    load_check("txdata_read", A_TX, 32'h0);
    load_check("rsvd_no_ram", 32'h0000_0020, 32'hCAFE_F00D);

    // Test 2: three bytes, then a drain
    store(A_TX, 32'hAAAA_AA41);
    store(A_TX, 32'h0000_0042);
    store(A_TX, 32'h5555_5543);
    load_check("fifo3_status", A_STATUS, 32'h0000_0300);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("drain3_valid%0d", i), 32'(tx_valid), 32'h1);
      check_val($sformatf("drain3_data%0d", i), 32'(tx_data), 32'h41 + 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    #1;
    check_val("drain3_empty_valid", 32'(tx_valid), 32'h0);
    check_val("drain3_empty_data", 32'(tx_data), 32'h0);
    load_check("drain3_status", A_STATUS, 32'h0000_0002);

    // Test 3: overflow on the ninth push; only the first eight bytes are kept
    for (int i = 0; i < 8; i++) store(A_TX, 32'h50 + 32'(i));
    load_check("full_status", A_STATUS, 32'h0000_0801);
    store(A_TX, 32'h0000_0058);
    load_check("ovf_status", A_STATUS, 32'h0000_0805);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_val($sformatf("ovf_drain%0d", i), 32'(tx_data), 32'h50 + 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    load_check("ovf_sticky", A_STATUS, 32'h0000_0006);
    store(A_STATUS, 32'hFFFF_FFFB);
    load_check("ovf_noclear", A_STATUS, 32'h0000_0006);
    store(A_STATUS, 32'h0000_0004);
    load_check("ovf_cleared", A_STATUS, 32'h0000_0002);

    // Test 4: push and pop together while the FIFO is full
    for (int i = 0; i < 8; i++) store(A_TX, 32'h60 + 32'(i));
    tx_ready = 1'b1;
    #1;
    check_val("fullpp_head", 32'(tx_data), 32'h60);
    store(A_TX, 32'h0000_0068);
    tx_ready = 1'b0;
    load_check("fullpp_status", A_STATUS, 32'h0000_0801);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_val($sformatf("fullpp_drain%0d", i), 32'(tx_data), 32'h61 + 32'(i));
      tick();
    end
    tx_ready = 1'b0;
    load_check("fullpp_empty", A_STATUS, 32'h0000_0002);

    // Test 6: reset mid-operation with 5 bytes queued and overflow set
    for (int i = 0; i < 9; i++) store(A_TX, 32'h70 + 32'(i));
    tx_ready = 1'b1;
    tick();
    tick();
    tick();
    tx_ready = 1'b0;
    load_check("pre_rst_status", A_STATUS, 32'h0000_0504);
    reset     = 1'b1;
    tx_ready  = 1'b1;
    MemWrite  = 1'b1;
    Addr      = A_TX;
    WriteData = 32'h0000_0099;
    tick();
    reset     = 1'b0;
    MemWrite  = 1'b0;
    tx_ready  = 1'b0;
    #1;
    check_val("post_rst_valid", 32'(tx_valid), 32'h0);
    check_val("post_rst_data", 32'(tx_data), 32'h0);
    load_check("post_rst_status", A_STATUS, 32'h0000_0002);
    load_check("post_rst_cycle", A_CYCLE, 32'h0);
    load_check("post_rst_ram20", 32'h0000_0020, 32'hCAFE_F00D);
    load_check("post_rst_ram10", 32'h0000_0010, 32'hDEAD_BEEF);
    store(A_TX, 32'h0000_0077);
    #1;
    check_val("post_rst_push", 32'(tx_data), 32'h77);
    load_check("post_rst_count1", A_STATUS, 32'h0000_0100);
    load_check("post_rst_cycle1", A_CYCLE, cyc_exp(32'h1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage consumed by the single-cycle RISC-V core.
- Takes the core's ALUResult (address), WriteData and MemWrite, and returns ReadData combinationally in the same cycle.
- Provides word RAM and a small MMIO window:
  - console TX FIFO drained by a valid/ready sink
  - status register
  - free-running cycle counter

Parameters:
- MEM_WORDS, 64, number of 32-bit RAM words; power of two, at least 4.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- MemWrite  input  1  store enable from core
- Addr  input  32  byte address (core ALUResult)
- WriteData  input  32  store data from core
- ReadData  output  32  load data, combinational from Addr and current state
- tx_valid  output  1  FIFO non-empty
- tx_data  output  8  FIFO head byte
- tx_ready  input  1  sink accepts head when tx_valid && tx_ready at a rising edge

Behaviour:
- Address decode:
  - Addr[31:28]==4'hF selects MMIO; otherwise RAM.
  - RAM word index = Addr[log2(MEM_WORDS)+1:2].
  - Addr[1:0] is ignored.
  - Upper RAM address bits are ignored, so RAM aliases.
- RAM:
  - Write on the rising edge when MemWrite and RAM selected.
  - Read is asynchronous.
  - Contents are not affected by reset; they are undefined until written.
- MMIO map (offset = Addr[3:0]; Addr[27:4] ignored):
  - 0x0 TXDATA:
    - Write pushes WriteData[7:0].
    - Read returns 0.
  - 0x4 STATUS, read value:
    - bit0 full
    - bit1 empty
    - bit2 overflow (sticky)
    - bits[15:8] count
    - other bits 0
  - 0x4 STATUS, write: WriteData[2]==1 clears overflow; other bits ignored.
  - 0x8 CYCLE:
    - Read returns the counter value.
    - Write loads WriteData.
  - 0xC: reads 0; writes ignored.
- Read timing: ReadData reflects state before the current edge. A store and a load of the same cycle do not exist (single-cycle core), but ReadData must never depend on same-cycle WriteData.
- FIFO:
  - Circular buffer with rd/wr pointers and count (0..FIFO_DEPTH).
  - Push request = MemWrite && MMIO && offset 0x0.
  - Pop = tx_valid && tx_ready.
  - Empty: pop impossible because tx_valid=0; tx_data = 0 when empty.
  - Full with push and no pop: byte dropped, overflow set to 1, pointers unchanged.
  - Full with push and pop in the same cycle: both performed, count stays FIFO_DEPTH, no overflow.
  - Push and pop both on a non-full, non-empty FIFO: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag:
  - Setting the flag and clearing it via STATUS cannot occur in the same cycle (single store per cycle).
  - If the flag is already set, a new overflow keeps it at 1.
- CYCLE counter:
  - 32-bit counter increments by 1 every clock.
  - Wraps 0xFFFFFFFF to 0.
  - A write loads WriteData exactly; the write wins over the increment, so the next read shows WriteData+1 one cycle later.
- Reset (synchronous):
  - FIFO emptied (tx_valid=0, tx_data=0).
  - overflow=0; CYCLE=0.
  - Reset asserted mid-drain discards all queued bytes.
  - A push on the reset cycle is ignored.
- Outputs after reset:
  - ReadData for MMIO: STATUS=0x0000_0002, CYCLE=0.
  - ReadData for RAM: whatever the RAM holds.

Optional Feature:
- Macro DMEM_CYCLE_CNT_EN.
- Defined: CYCLE counter present, as described above.
- Undefined:
  - No counter register is built.
  - Offset 0x8 reads 0.
  - Writes to offset 0x8 are ignored.

Test Plan:
1. RAM store/load: write 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> 0xDEADBEEF; load 0x0000_0013 -> 0xDEADBEEF; with MEM_WORDS=64, load 0x0000_0110 -> 0xDEADBEEF (alias).
2. FIFO drain: tx_ready=0; push 0x41, 0x42, 0x43 to 0xF000_0000 -> STATUS=0x0000_0300. Then tx_ready=1 -> tx_data 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0 and STATUS=0x0000_0002.
3. Overflow: tx_ready=0; push 9 bytes with FIFO_DEPTH=8 -> STATUS=0x0000_0805; drained bytes are the first 8 only. Write 0x4 to 0xF000_0004 -> bit2 clears.
4. Full with simultaneous push+pop: FIFO full; tx_ready=1 and a push in the same cycle -> count stays 8, overflow stays 0, new byte appears last in the drain order.
5. CYCLE: after reset deassertion read 0xF000_0008 on successive cycles -> 0, 1, 2. Write 0xFFFFFFFE -> next cycles read 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. With DMEM_CYCLE_CNT_EN undefined -> always 0.
6. Reset mid-operation: 5 bytes queued, overflow set, reset for 1 cycle -> tx_valid=0, STATUS=0x0000_0002, CYCLE=0; RAM word written before reset still reads back unchanged.
